// File: rtl/serial_operand_feeder.sv
// Parallel-to-serial operand feeder for a bit-serial adder: shifts an A/B pair out
// LSB-first inside a start-high frame of W+1 bits, then holds start low for the carry clear.
module serial_operand_feeder #(
   parameter int W          = 8,
   parameter bit SIGNED     = 1'b0,
   parameter int GAP_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   output logic         a_ser,
   output logic         b_ser,
   output logic         start,
   output logic         busy,
   output logic         frame_last
);

   localparam int CW = $clog2(W + 1);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(W);
   localparam logic [CW-1:0] PRE_LAST = CW'(W - 1);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]      gap_cnt_q, gap_cnt_d;
   logic [1:0][W-1:0]  sh_q, sh_d;
   logic [1:0][W-1:0]  load_val;
   logic [1:0]         load_bit0;
   logic [1:0]         ser_q, ser_d;
   logic               start_q, start_d;
   logic               busy_q, busy_d;
   logic               last_q, last_d;
   logic               accept;

   // Lane 0 carries A, lane 1 carries B. Bit 0 goes straight to the output on accept;
   // the shift register keeps the remaining bits with the extension bit on top.
   for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      logic [W-1:0] op;
      assign op            = (gi == 0) ? a_in : b_in;
      assign load_val[gi]  = {(SIGNED ? op[W-1] : 1'b0), op[W-1:1]};
      assign load_bit0[gi] = op[0];
   end

   assign in_ready = (state_q == S_IDLE) ||
                     ((state_q == S_GAP) && (gap_cnt_q == LAST_GAP));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      sh_d      = sh_q;
      ser_d     = '0;
      start_d   = 1'b0;
      busy_d    = 1'b0;
      last_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
         end
         S_SHIFT: begin
            busy_d = 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
               state_d   = S_GAP;
               gap_cnt_d = '0;
            end else begin
               bit_cnt_d = bit_cnt_q + CW'(1);
               start_d   = 1'b1;
               last_d    = (bit_cnt_q == PRE_LAST);
               for (int k = 0; k < 2; k++) begin
                  ser_d[k] = sh_q[k][0];
                  sh_d[k]  = sh_q[k] >> 1;
               end
            end
         end
         S_GAP: begin
            busy_d = 1'b1;
            if (gap_cnt_q == LAST_GAP) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Accept is only possible in IDLE or the final GAP cycle, so it overrides either.
      if (accept) begin
         state_d   = S_SHIFT;
         bit_cnt_d = '0;
         sh_d      = load_val;
         ser_d     = load_bit0;
         start_d   = 1'b1;
         busy_d    = 1'b1;
         last_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         sh_q      <= '0;
         ser_q     <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         sh_q      <= sh_d;
         ser_q     <= ser_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         last_q    <= last_d;
      end
   end

   assign a_ser      = ser_q[0];
   assign b_ser      = ser_q[1];
   assign start      = start_q;
   assign busy       = busy_q;
   assign frame_last = last_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: a zero-extending and a sign-extending instance share
// stimulus; a slot-queue model and a bit-serial adder reassembly check them every cycle.
module tb_serial_operand_feeder;

   localparam int W   = 8;
   localparam int GAP = 1;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a_in, b_in;
   logic [1:0]   rdy, a_s, b_s, st, bz, fl;

   serial_operand_feeder #(.W(W), .SIGNED(1'b0), .GAP_CYCLES(GAP)) dut_u (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]),
      .a_in(a_in), .b_in(b_in), .a_ser(a_s[0]), .b_ser(b_s[0]),
      .start(st[0]), .busy(bz[0]), .frame_last(fl[0]));

   serial_operand_feeder #(.W(W), .SIGNED(1'b1), .GAP_CYCLES(GAP)) dut_s (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]),
      .a_in(a_in), .b_in(b_in), .a_ser(a_s[1]), .b_ser(b_s[1]),
      .start(st[1]), .busy(bz[1]), .frame_last(fl[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model: one slot per future output cycle ----------------
   typedef struct { bit frame; logic [W-1:0] a; logic [W-1:0] b; int idx; } slot_t;
   typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;
   typedef struct { logic [W:0] a; logic [W:0] b; logic [W:0] s; int gap; } rec_t;

   slot_t sched[$];
   pair_t acc0[$], acc1[$];
   rec_t  recs0[$], recs1[$];

   function automatic bit model_ready();
      return (sched.size() == 0) || (sched.size() == 1 && !sched[0].frame);
   endfunction

   function automatic logic exp_bit(input logic [W-1:0] v, input int idx, input bit sgn);
      if (idx < W) return v[idx];
      return sgn ? v[W-1] : 1'b0;
   endfunction

   function automatic int exp_sum(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
      int ea, eb;
      ea = int'(a);
      eb = int'(b);
      if (sgn && a[W-1]) ea += (1 << W);
      if (sgn && b[W-1]) eb += (1 << W);
      return (ea + eb) % (1 << (W + 1));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sched.delete();
         acc0.delete();
         acc1.delete();
      end else begin
         bit    take;
         slot_t sl;
         pair_t p;
         take = in_valid && model_ready();
         if (sched.size() > 0) sched.delete(0);
         if (take) begin
            for (int i = 0; i <= W; i++) begin
               sl.frame = 1'b1; sl.a = a_in; sl.b = b_in; sl.idx = i;
               sched.push_back(sl);
            end
            for (int g = 0; g < GAP; g++) begin
               sl.frame = 1'b0; sl.a = '0; sl.b = '0; sl.idx = 0;
               sched.push_back(sl);
            end
            p.a = a_in; p.b = b_in;
            acc0.push_back(p);
            acc1.push_back(p);
         end
      end
   end

   // ---------------- per-cycle compare plus serial-adder reassembly ----------------
   int         col_idx [2];
   int         low_run [2];
   int         cur_gap [2];
   logic       cy      [2];
   logic [W:0] col_a   [2];
   logic [W:0] col_b   [2];
   logic [W:0] col_s   [2];

   initial begin
      for (int k = 0; k < 2; k++) begin
         col_idx[k] = 0; low_run[k] = 0; cur_gap[k] = 0; cy[k] = 1'b0;
         col_a[k] = '0; col_b[k] = '0; col_s[k] = '0;
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         logic  e_st, e_a, e_b, e_fl, e_bz, sbit;
         pair_t p;
         rec_t  r;
         bit    have;
         e_st = 1'b0; e_a = 1'b0; e_b = 1'b0; e_fl = 1'b0; e_bz = 1'b0;
         if (sched.size() > 0) begin
            e_bz = 1'b1;
            if (sched[0].frame) begin
               e_st = 1'b1;
               e_a  = exp_bit(sched[0].a, sched[0].idx, k == 1);
               e_b  = exp_bit(sched[0].b, sched[0].idx, k == 1);
               e_fl = (sched[0].idx == W);
            end
         end
         check($sformatf("inst%0d start", k),      32'(st[k]),  32'(e_st));
         check($sformatf("inst%0d a_ser", k),      32'(a_s[k]), 32'(e_a));
         check($sformatf("inst%0d b_ser", k),      32'(b_s[k]), 32'(e_b));
         check($sformatf("inst%0d busy", k),       32'(bz[k]),  32'(e_bz));
         check($sformatf("inst%0d frame_last", k), 32'(fl[k]),  32'(e_fl));
         check($sformatf("inst%0d in_ready", k),   32'(rdy[k]), 32'(model_ready()));

         if (!rst_n) begin
            col_idx[k] = 0; cy[k] = 1'b0; low_run[k] = 0;
         end else if (st[k] === 1'b1) begin
            if (col_idx[k] == 0) begin
               cur_gap[k] = low_run[k];
               col_a[k] = '0; col_b[k] = '0; col_s[k] = '0; cy[k] = 1'b0;
            end
            if (col_idx[k] <= W) begin
               sbit = a_s[k] ^ b_s[k] ^ cy[k];
               col_a[k][col_idx[k]] = a_s[k];
               col_b[k][col_idx[k]] = b_s[k];
               col_s[k][col_idx[k]] = sbit;
               cy[k] = (a_s[k] & b_s[k]) | (cy[k] & (a_s[k] ^ b_s[k]));
            end
            col_idx[k]++;
            low_run[k] = 0;
            if (fl[k] === 1'b1) begin
               r.a = col_a[k]; r.b = col_b[k]; r.s = col_s[k]; r.gap = cur_gap[k];
               have = 1'b0;
               if (k == 0) begin
                  recs0.push_back(r);
                  if (acc0.size() > 0) begin p = acc0.pop_front(); have = 1'b1; end
               end else begin
                  recs1.push_back(r);
                  if (acc1.size() > 0) begin p = acc1.pop_front(); have = 1'b1; end
               end
               if (!have) begin
                  tests++; fails++;
                  $display("FAIL inst%0d frame: got a frame with sum %0h, expected no frame", k, r.s);
               end else begin
                  check($sformatf("inst%0d frame sum", k), 32'(r.s), 32'(exp_sum(p.a, p.b, k == 1)));
               end
               col_idx[k] = 0;
            end
         end else begin
            low_run[k]++;
            col_idx[k] = 0;
            cy[k] = 1'b0;
         end
      end
   end

   // ---------------- stimulus ----------------
   int txn = 0;

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int waits);
      logic r;
      a_in = a; b_in = b; in_valid = 1'b1; waits = 0;
      while (1) begin
         r = rdy[0];
         @(posedge clk);
         @(negedge clk);
         waits++;
         if (r === 1'b1) break;
         if (waits > 200) begin
            tests++; fails++;
            $display("FAIL handshake: no in_ready within %0d cycles, expected acceptance", waits);
            break;
         end
      end
      $display("[TB] txn %0d a=%h b=%h accepted after %0d cycles", txn, a, b, waits);
      txn++;
      in_valid = 1'b0;
      a_in = W'($urandom);
      b_in = W'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int w1, w2;
      rst_n = 1'b0; in_valid = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("reset in_ready", 32'(rdy), 32'(2'b11));
      check("reset start",    32'(st),  32'(2'b00));
      check("reset busy",     32'(bz),  32'(2'b00));
      idle(4);

      send(8'h5A, 8'h3C, w1); idle(W + GAP + 3);
      send(8'h80, 8'hFF, w1); idle(W + GAP + 3);

      // held valid: the second pair must go in the final GAP cycle
      send(8'hFF, 8'h01, w1);
      send(8'h01, 8'h01, w2);
      check("back-to-back accept delay", 32'(w2), 32'(W + 1 + GAP));
      idle(W + GAP + 3);

      send(8'h12, 8'h34, w1);
      send(8'h56, 8'h78, w2);
      check("backpressure accept delay", 32'(w2), 32'(W + 1 + GAP));
      idle(W + GAP + 3);

      // reset while bit 4 is on the lines
      send(8'h11, 8'h22, w1);
      idle(4);
      #2 rst_n = 1'b0;
      #1;
      check("async reset start", 32'(st),  32'(2'b00));
      check("async reset a_ser", 32'(a_s), 32'(2'b00));
      check("async reset b_ser", 32'(b_s), 32'(2'b00));
      check("async reset busy",  32'(bz),  32'(2'b00));
      @(negedge clk);
      #2 rst_n = 1'b1;
      idle(3);
      send(8'h03, 8'h05, w1);
      idle(W + GAP + 3);

      if (recs0.size() < 7 || recs1.size() < 7) begin
         tests++; fails++;
         $display("FAIL directed frames: got %0d/%0d frames, expected 7", recs0.size(), recs1.size());
      end else begin
         check("frame0 a bits",   32'(recs0[0].a), 32'h05A);
         check("frame0 b bits",   32'(recs0[0].b), 32'h03C);
         check("frame0 sum",      32'(recs0[0].s), 32'h096);
         check("signed a bits",   32'(recs1[1].a), 32'h180);
         check("signed b bits",   32'(recs1[1].b), 32'h1FF);
         check("signed sum",      32'(recs1[1].s), 32'h17F);
         check("b2b sum1",        32'(recs0[2].s), 32'h100);
         check("b2b sum2",        32'(recs0[3].s), 32'h002);
         check("b2b low cycles",  32'(recs0[3].gap), 32'(1));
         check("post-reset sum",  32'(recs0[6].s), 32'h008);
      end

      for (int t = 0; t < 250; t++) begin
         send(W'($urandom), W'($urandom), w1);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 4));
      end
      idle(W + GAP + 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
